// File: rtl/floor_request_encoder.sv
// Call-button front end: synchronise, debounce and latch floor calls, then issue them to the request FIFO one at a time.
// Optional macro ALARM_FLUSH_EN: the rising edge of i_alarm discards all latched calls.
module floor_request_encoder #(
  parameter int NUM_FLOORS      = 16,
  parameter int FLOOR_W         = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NUM_FLOORS-1:0] i_buttons,
  input  logic                  i_fifo_full,
  input  logic [FLOOR_W-1:0]    i_current_floor,
  input  logic                  i_open_door,
  input  logic                  i_alarm,
  output logic                  o_wr_en,
  output logic [FLOOR_W-1:0]    o_floor_no,
  output logic [NUM_FLOORS-1:0] o_pending
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2} state_t;

  state_t                state_r;
  logic [NUM_FLOORS-1:0] sync1_r, sync2_r, deb_r, pending_r, sent_r;
  logic [CNT_W-1:0]      cnt_r [NUM_FLOORS];
  logic [FLOOR_W-1:0]    ptr_r;
  logic                  wr_en_r;
  logic [FLOOR_W-1:0]    floor_r;
`ifdef ALARM_FLUSH_EN
  logic                  alarm_r;
`endif

  logic [NUM_FLOORS-1:0] rise_s, clear_s, cand_s, pending_nx_s, sent_nx_s;
  logic [FLOOR_W:0]      pick_res_s;
  logic [FLOOR_W-1:0]    pick_s, ptr_nx_s;
  logic                  found_s, issue_s, flush_s;

  // Lowest rotated offset from ptr wins: scan downwards so the last hit is the nearest.
  function automatic logic [FLOOR_W:0] pick_first(input logic [NUM_FLOORS-1:0] cand,
                                                  input logic [FLOOR_W-1:0]    ptr);
    logic [FLOOR_W:0] res;
    int               idx;
    res = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_FLOORS;
      if (cand[idx]) res = {1'b1, FLOOR_W'(idx)};
      else           res = res;
    end
    return res;
  endfunction

  // Per-floor debounce acceptance and door-open clear masks.
  always_comb begin
    rise_s  = '0;
    clear_s = '0;
    for (int k = 0; k < NUM_FLOORS; k++) begin
      rise_s[k]  = sync2_r[k] && !deb_r[k] && (cnt_r[k] == CNT_W'(DEBOUNCE_CYCLES - 1));
      clear_s[k] = i_open_door && (i_current_floor == FLOOR_W'(k));
    end
  end

  // Issue selection and next-state of the call bitmaps.
  always_comb begin
    cand_s     = pending_r & ~sent_r;
    pick_res_s = pick_first(cand_s, ptr_r);
    found_s    = pick_res_s[FLOOR_W];
    pick_s     = pick_res_s[FLOOR_W-1:0];
    // A call cleared on this edge is not issued, and nothing else is picked in its place.
    issue_s    = (state_r == IDLE) && found_s && !clear_s[pick_s] && !i_fifo_full && !i_alarm;
    if (pick_s == FLOOR_W'(NUM_FLOORS - 1)) ptr_nx_s = '0;
    else                                    ptr_nx_s = pick_s + FLOOR_W'(1);
`ifdef ALARM_FLUSH_EN
    flush_s = i_alarm && !alarm_r;
`else
    flush_s = 1'b0;
`endif
    pending_nx_s = (pending_r | rise_s) & ~clear_s;
    sent_nx_s    = sent_r & ~clear_s;
    if (issue_s) sent_nx_s[pick_s] = 1'b1;
    else         sent_nx_s = sent_nx_s;
    if (flush_s) begin
      pending_nx_s = '0;
      sent_nx_s    = '0;
    end else begin
      pending_nx_s = pending_nx_s;
    end
  end

  // Synchronisers, debounce counters, call bitmaps and the issue FSM.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1_r   <= '0;
      sync2_r   <= '0;
      deb_r     <= '0;
      pending_r <= '0;
      sent_r    <= '0;
      ptr_r     <= '0;
      state_r   <= IDLE;
      wr_en_r   <= 1'b0;
      floor_r   <= '0;
      for (int k = 0; k < NUM_FLOORS; k++) cnt_r[k] <= '0;
`ifdef ALARM_FLUSH_EN
      alarm_r   <= 1'b0;
`endif
    end else begin
      sync1_r <= i_buttons;
      sync2_r <= sync1_r;
      for (int k = 0; k < NUM_FLOORS; k++) begin
        if (sync2_r[k] == deb_r[k]) begin
          cnt_r[k] <= '0;
        end else if (cnt_r[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_r[k] <= sync2_r[k];
          cnt_r[k] <= '0;
        end else begin
          cnt_r[k] <= cnt_r[k] + CNT_W'(1);
        end
      end
      pending_r <= pending_nx_s;
      sent_r    <= sent_nx_s;
`ifdef ALARM_FLUSH_EN
      alarm_r   <= i_alarm;
`endif
      case (state_r)
        IDLE: begin
          if (issue_s) begin
            wr_en_r <= 1'b1;
            floor_r <= pick_s;
            ptr_r   <= ptr_nx_s;
            state_r <= ISSUE;
          end else begin
            wr_en_r <= 1'b0;
          end
        end
        ISSUE: begin
          wr_en_r <= 1'b0;
          state_r <= GAP;
        end
        GAP: begin
          wr_en_r <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          wr_en_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
      if (flush_s) ptr_r <= '0;
    end
  end

  assign o_wr_en    = wr_en_r;
  assign o_floor_no = floor_r;
  assign o_pending  = pending_r;

endmodule

// File: tb/tb_floor_request_encoder.sv
// Bench for floor_request_encoder: directed table, hand sequences and random traffic against a behavioural model.
module tb_floor_request_encoder;
  localparam int N = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn = '0;
  logic         full = 1'b0;
  logic [3:0]   cur = '0;
  logic         door = 1'b0;
  logic         alarm = 1'b0;
  logic         wr_en;
  logic [3:0]   floor_no;
  logic [N-1:0] pending;

  floor_request_encoder dut (
    .i_clock(clk), .i_reset(rst), .i_buttons(btn), .i_fifo_full(full),
    .i_current_floor(cur), .i_open_door(door), .i_alarm(alarm),
    .o_wr_en(wr_en), .o_floor_no(floor_no), .o_pending(pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int seg_cnt;
  int seg_last;

  // Behavioural model: button seen two edges late, accepted after D consecutive differing edges.
  logic [N-1:0] d1, d2;
  bit   m_deb [N];
  int   m_run [N];
  bit   m_pend [N];
  bit   m_sent [N];
  int   m_ptr, m_busy, m_floor;
  bit   m_wr, m_alarm_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] m_pend_vec();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = m_pend[k];
    return v;
  endfunction

  task automatic model_update();
    logic [N-1:0] seen;
    bit rise [N];
    bit clr [N];
    int idx;
    bit found;
    if (rst) begin
      d1 = '0; d2 = '0;
      for (int k = 0; k < N; k++) begin
        m_deb[k] = 0; m_run[k] = 0; m_pend[k] = 0; m_sent[k] = 0;
      end
      m_ptr = 0; m_busy = 0; m_wr = 0; m_floor = 0; m_alarm_prev = 0;
      return;
    end
    seen = d2; d2 = d1; d1 = btn;
    for (int k = 0; k < N; k++) begin
      rise[k] = 0;
      clr[k] = door && (int'(cur) == k);
      if (seen[k] != m_deb[k]) begin
        m_run[k]++;
        if (m_run[k] == D) begin
          m_deb[k] = seen[k];
          m_run[k] = 0;
          rise[k] = seen[k];
        end
      end else begin
        m_run[k] = 0;
      end
    end
    m_wr = 0;
    if (m_busy > 0) begin
      m_busy--;
    end else if (!full && !alarm) begin
      found = 0; idx = 0;
      for (int i = 0; i < N && !found; i++) begin
        idx = (m_ptr + i) % N;
        if (m_pend[idx] && !m_sent[idx]) found = 1;
      end
      if (found && !clr[idx]) begin
        m_wr = 1; m_floor = idx; m_sent[idx] = 1;
        m_ptr = (idx + 1) % N; m_busy = 2;
      end
    end
    for (int k = 0; k < N; k++) begin
      m_pend[k] = (m_pend[k] | rise[k]) & !clr[k];
      if (clr[k]) m_sent[k] = 0;
    end
`ifdef ALARM_FLUSH_EN
    if (alarm && !m_alarm_prev) begin
      for (int k = 0; k < N; k++) begin m_pend[k] = 0; m_sent[k] = 0; end
      m_ptr = 0;
    end
`endif
    m_alarm_prev = alarm;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("wr_en", {31'd0, wr_en}, {31'd0, m_wr});
    if (m_wr) chk("floor_no", {28'd0, floor_no}, m_floor);
    chk("pending", {16'd0, pending}, {16'd0, m_pend_vec()});
    if (wr_en) begin seg_cnt++; seg_last = int'(floor_no); end
  endtask

  typedef struct {
    bit          rst;
    logic [15:0] btn;
    bit          full;
    bit          door;
    logic [3:0]  cur;
    bit          alarm;
    int          cyc;
    logic [15:0] exp_pend;
    int          exp_cnt;
    int          exp_last;
  } vec_t;

  vec_t tbl[$];

  initial begin
`ifdef ALARM_FLUSH_EN
    localparam logic [15:0] PEND_ALARM = 16'h0000;
    localparam int CNT_AFTER = 0;
`else
    localparam logic [15:0] PEND_ALARM = 16'h0840;
    localparam int CNT_AFTER = 2;
`endif
    // reset with toggling buttons
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      btn = (i == 0) ? 16'hFFFF : 16'h5A5A;
      step();
      chk("reset_wr", {31'd0, wr_en}, 32'd0);
      chk("reset_floor", {28'd0, floor_no}, 32'd0);
      chk("reset_pend", {16'd0, pending}, 32'd0);
    end
    btn = '0; rst = 1'b0;
    step();
    chk("post_reset_wr", {31'd0, wr_en}, 32'd0);
    chk("post_reset_pend", {16'd0, pending}, 32'd0);

    //           rst  btn       full door cur   alarm cyc pend      cnt last
    tbl.push_back('{1'b1, 16'hA5A5, 1'b0, 1'b0, 4'd0, 1'b0, 2,  16'h0000, 0, 0});
    tbl.push_back('{1'b0, 16'h0080, 1'b0, 1'b0, 4'd0, 1'b0, 5,  16'h0000, 0, 0});
    tbl.push_back('{1'b0, 16'h0080, 1'b0, 1'b0, 4'd0, 1'b0, 1,  16'h0080, 0, 0});
    tbl.push_back('{1'b0, 16'h0080, 1'b0, 1'b0, 4'd0, 1'b0, 1,  16'h0080, 1, 7});
    tbl.push_back('{1'b0, 16'h0080, 1'b0, 1'b0, 4'd0, 1'b0, 6,  16'h0080, 0, 0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 8,  16'h0080, 0, 0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 4'd7, 1'b0, 1,  16'h0000, 0, 0});
    tbl.push_back('{1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1,  16'h0000, 0, 0});
    tbl.push_back('{1'b0, 16'h0224, 1'b0, 1'b0, 4'd0, 1'b0, 6,  16'h0224, 0, 0});
    tbl.push_back('{1'b0, 16'h0224, 1'b0, 1'b0, 4'd0, 1'b0, 7,  16'h0224, 3, 9});
    tbl.push_back('{1'b0, 16'h1226, 1'b0, 1'b0, 4'd0, 1'b0, 20, 16'h1226, 2, 1});
    tbl.push_back('{1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1,  16'h0000, 0, 0});
    tbl.push_back('{1'b0, 16'h0010, 1'b1, 1'b0, 4'd0, 1'b0, 6,  16'h0010, 0, 0});
    tbl.push_back('{1'b0, 16'h0010, 1'b1, 1'b0, 4'd0, 1'b0, 10, 16'h0010, 0, 0});
    tbl.push_back('{1'b0, 16'h0010, 1'b0, 1'b0, 4'd0, 1'b0, 2,  16'h0010, 1, 4});
    tbl.push_back('{1'b0, 16'h0010, 1'b0, 1'b1, 4'd4, 1'b0, 1,  16'h0000, 0, 0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 8,  16'h0000, 0, 0});
    tbl.push_back('{1'b0, 16'h0010, 1'b0, 1'b1, 4'd4, 1'b0, 10, 16'h0000, 0, 0});
    tbl.push_back('{1'b0, 16'h0010, 1'b0, 1'b0, 4'd0, 1'b0, 4,  16'h0000, 0, 0});
    tbl.push_back('{1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1,  16'h0000, 0, 0});
    tbl.push_back('{1'b0, 16'h0840, 1'b1, 1'b0, 4'd0, 1'b0, 6,  16'h0840, 0, 0});
    tbl.push_back('{1'b0, 16'h0840, 1'b0, 1'b0, 4'd0, 1'b1, 1,  PEND_ALARM, 0, 0});
    tbl.push_back('{1'b0, 16'h0840, 1'b0, 1'b0, 4'd0, 1'b1, 8,  PEND_ALARM, 0, 0});
    tbl.push_back('{1'b0, 16'h0840, 1'b0, 1'b0, 4'd0, 1'b0, 6,  PEND_ALARM, CNT_AFTER, 11});

    foreach (tbl[n]) begin
      rst = tbl[n].rst; btn = tbl[n].btn; full = tbl[n].full;
      door = tbl[n].door; cur = tbl[n].cur; alarm = tbl[n].alarm;
      seg_cnt = 0; seg_last = -1;
      repeat (tbl[n].cyc) step();
      chk($sformatf("tbl%0d_pend", n), {16'd0, pending}, {16'd0, tbl[n].exp_pend});
      chk($sformatf("tbl%0d_strobes", n), seg_cnt, tbl[n].exp_cnt);
      if (tbl[n].exp_cnt > 0) chk($sformatf("tbl%0d_last", n), seg_last, tbl[n].exp_last);
    end

    // bouncing button never debounces
    rst = 1'b1; btn = '0; alarm = 1'b0; full = 1'b0; door = 1'b0;
    step();
    rst = 1'b0; seg_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      btn = 16'h0008; step(); step();
      btn = 16'h0000; step(); step();
    end
    repeat (10) step();
    chk("bounce_pend", {16'd0, pending}, 32'd0);
    chk("bounce_strobes", seg_cnt, 0);

    // reset on the edge that would issue drops the strobe
    btn = 16'h0001;
    repeat (6) step();
    chk("pre_issue_pend", {16'd0, pending}, 32'h0001);
    rst = 1'b1; step();
    chk("reset_issue_wr", {31'd0, wr_en}, 32'd0);
    chk("reset_issue_pend", {16'd0, pending}, 32'd0);
    rst = 1'b0; btn = '0;
    repeat (4) step();

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) btn[$urandom_range(N-1)] ^= 1'b1;
      full  = ($urandom_range(3) == 0);
      door  = ($urandom_range(5) == 0);
      cur   = 4'($urandom_range(15));
      if ($urandom_range(39) == 0) alarm = ~alarm;
      rst   = ($urandom_range(499) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
